ram_chip: RTL and testbench
===========================

RAM_CHIP -- requirements
Module: ram_chip

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 4 and give the address width (depth = 2^ADDR_W = 16 words).
REQ-003 Parameter DATA_W SHALL default to 8 and give the word width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-005 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port address SHALL be an input, ADDR_W bits wide, and selects the word.
REQ-007 Port data SHALL be an inout, DATA_W bits wide: a shared bidirectional bus, driven by the block only during reads.
REQ-008 Port CEb SHALL be an input, 1 bit wide: active-low chip enable.
REQ-009 Port WEb SHALL be an input, 1 bit wide: active-low write enable.
REQ-010 Port OEb SHALL be an input, 1 bit wide: active-low output enable.
REQ-011 Port parity_err SHALL be an output, 1 bit wide, present only with RAM_CHIP_PARITY_EN (see Configuration).

Function
REQ-012 Storage SHALL be 2^ADDR_W words of DATA_W bits, held in array mem_q, with no wrap or aliasing beyond the address width.
REQ-013 Write: on a rising clk with rst=0, CEb=0 and WEb=0, mem_q[address] SHALL take the data bus value; the new word is readable from the next cycle.
REQ-014 Read: while CEb=0, OEb=0, WEb=1 and rst=0, data SHALL be driven combinationally with mem_q[address], with zero-cycle latency after an address change.
REQ-015 In every other combination, including CEb=1 (any WEb/OEb), WEb=0 (write has priority over OEb) and rst=1, data SHALL be high-impedance (all bits Z).
REQ-016 A read and a write SHALL never both be active, so the block never drives the bus it is sampling.
REQ-017 A write with X/Z bits on data SHALL store them unchanged; no checking is performed.
REQ-018 With CEb=1, WEb and OEb SHALL be ignored.

Reset
REQ-019 On a rising clk with rst=1, every mem_q word SHALL be cleared to 0 in that single cycle.
REQ-020 While rst=1, writes SHALL be ignored and data SHALL be Z; rst has priority over all other controls.
REQ-021 Reset asserted mid-access SHALL abort the access; after rst falls, a read of any address SHALL return 0x00 until that address is written.
REQ-022 Before the first reset, memory contents SHALL be X, and reads SHALL return X.

Configuration
REQ-023 Macro RAM_CHIP_PARITY_EN SHALL, when defined, add a per-word even-parity bit in array par_q, written with each write as the XOR of the data word and cleared to 0 on reset.
REQ-024 With RAM_CHIP_PARITY_EN, parity_err SHALL be 1 during an active read when the XOR of mem_q[address] and par_q[address] is 1, and 0 otherwise.
REQ-025 Without RAM_CHIP_PARITY_EN, there SHALL be no par_q array and no parity_err port; all other behaviour is identical.

Verification
REQ-026 Idle, CEb=WEb=OEb=1 after reset -> data reads 8'bzzzzzzzz.
REQ-027 Reset, write 0xA5 at address 3 (CEb=0, WEb=0, one clk), then read address 3 (OEb=0, WEb=1) -> data=0xA5, and address 4 reads 0x00.
REQ-028 Write 0x3C at address 15 and 0xC3 at address 0 -> each reads back its own value, with no aliasing.
REQ-029 CEb=0, WEb=0, OEb=0, bench drives 0x5A at address 7 -> data is not driven by the block during the cycle, and a later read of address 7 returns 0x5A.
REQ-030 Write 0xFF at address 2, pulse rst for one clk mid-read -> data=Z while rst=1, then reads 0x00.
REQ-031 With RAM_CHIP_PARITY_EN, write 0x01 at address 5 and deposit par_q[5]=0 -> a read of address 5 gives parity_err=1; a fresh write of 0x01 -> parity_err=0.

Source files
------------

// File: rtl/ram_chip.sv
// Synchronous-write / asynchronous-read SRAM model with a shared tristate data bus.
// Optional per-word even parity is enabled by defining RAM_CHIP_PARITY_EN.
module ram_chip #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    input  logic              CEb,
    input  logic              WEb,
`ifdef RAM_CHIP_PARITY_EN
    input  logic              OEb,
    output logic              parity_err
`else
    input  logic              OEb
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              write_en;
    logic              read_en;

    // Reset outranks everything; a write blocks the read so the bus is never self-driven.
    assign write_en = !rst && !CEb && !WEb;
    assign read_en  = !rst && !CEb && WEb && !OEb;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[address] <= data;
        end
    end

    assign data = read_en ? mem_q[address] : 'z;

`ifdef RAM_CHIP_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
        end else if (write_en) begin
            par_q[address] <= ^data;
        end
    end

    // Stored word plus its parity bit must XOR to zero.
    assign parity_err = read_en & ((^mem_q[address]) ^ par_q[address]);
`endif

endmodule

// File: tb/tb_ram_chip.sv
// Directed bench for ram_chip: a vector table for the main read/write paths
// plus hand-written sequences for reset-mid-access and the parity option.
module tb_ram_chip;

    logic       clk;
    logic       rst;
    logic [3:0] address;
    logic       CEb;
    logic       WEb;
    logic       OEb;
    logic       drv_en;
    logic [7:0] drv;
    wire  [7:0] data;
`ifdef RAM_CHIP_PARITY_EN
    logic       parity_err;
`endif

    int passed;
    int total;

    // Bench side of the shared bus; "not driven by the DUT" is checked by
    // driving a value here and requiring the bus to show exactly that value.
    assign data = drv_en ? drv : 8'bzzzzzzzz;

    ram_chip #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data       (data),
        .CEb        (CEb),
        .WEb        (WEb),
`ifdef RAM_CHIP_PARITY_EN
        .OEb        (OEb),
        .parity_err (parity_err)
`else
        .OEb        (OEb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       ce;
        logic       we;
        logic       oe;
        logic [3:0] a;
        logic       de;
        logic [7:0] dv;
        logic [7:0] exp;
        string      name;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_in(input logic r, input logic ce, input logic we, input logic oe,
                          input logic [3:0] a, input logic de, input logic [7:0] dv);
        rst = r; CEb = ce; WEb = we; OEb = oe; address = a; drv_en = de; drv = dv;
    endtask

    // Apply inputs after a falling edge, check the bus, then cross one rising edge.
    task automatic step(input vec_t v);
        set_in(v.r, v.ce, v.we, v.oe, v.a, v.de, v.dv);
        #1;
        check(v.name, data, v.exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00);

        //          rst   CEb   WEb   OEb   addr   drv   dval   exp
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 8'h00, 8'h00, "rst_read_hiz"};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 8'h00, 8'h00, "idle_hiz"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 8'hA5, 8'hA5, "wr3_a5"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 8'h00, 8'hA5, "rd3"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 8'h00, 8'h00, "rd4_zero"};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 8'h00, 8'h00, "ceb_hi_hiz"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 8'h00, 8'h00, "oeb_hi_hiz"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 8'h3C, 8'h3C, "wr15_3c"};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'hC3, 8'hC3, "wr0_c3"};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 8'h00, 8'h3C, "rd15"};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'h00, 8'hC3, "rd0"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 8'h00, 8'hA5, "rd3_again"};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 8'h5A, 8'h5A, "wr7_oeb_lo"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 8'h00, 8'h5A, "rd7"};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  1'b1, 8'h00, 8'h00, "wr3_oeb_lo_hiz"};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 8'h00, 8'h00, "rd3_cleared"};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 8'h00, 8'h00, "ceb_hi_wr_hiz"};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 8'h00, 8'h3C, "rd15_kept"};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 8'hFF, 8'hFF, "wr2_ff"};

        @(negedge clk);
        for (int i = 0; i < NV; i++) step(vecs[i]);

        // Reset raised in the middle of a read must release the bus at once.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'h00);
        #1;
        check("rd2_ff", data, 8'hFF);
        #1;
        rst = 1'b1; drv_en = 1'b1; drv = 8'h00;
        #1;
        check("rst_mid_read_hiz", data, 8'h00);
        @(posedge clk);
        @(negedge clk);

        // A write attempted under reset is dropped.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 8'h77);
        @(posedge clk);
        @(negedge clk);

        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 8'h00);
        #1;
        check("rd2_after_rst", data, 8'h00);
        address = 4'd9;
        #1;
        check("rd9_wr_in_rst_ignored", data, 8'h00);
        address = 4'd15;
        #1;
        check("rd15_after_rst", data, 8'h00);
        address = 4'd7;
        #1;
        check("rd7_after_rst", data, 8'h00);
        @(negedge clk);

`ifdef RAM_CHIP_PARITY_EN
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 8'h01);
        @(posedge clk);
        @(negedge clk);
        dut.par_q[5] = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 8'h00);
        #1;
        check("par_err_set", {7'd0, parity_err}, 8'h01);
        OEb = 1'b1;
        #1;
        check("par_err_no_read", {7'd0, parity_err}, 8'h00);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 8'h01);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 8'h00);
        #1;
        check("par_err_clear", {7'd0, parity_err}, 8'h00);
        @(negedge clk);
`endif

        set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
